// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the program counter, presents the
// fetch address to a combinational instruction memory, and captures the
// returned word into the IF/ID pipeline register. Handles stall (hold),
// redirect (load target and flush IF/ID), and keeps a saturating count of
// instructions accepted into IF/ID for performance debug.
module if_stage #(
  parameter int unsigned          PC_W     = 10,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter logic [31:0]          NOP_INS  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     Ins,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     if_id_ins,
  output logic [PC_W-1:0] if_id_pc,
  output logic [PC_W-1:0] if_id_pc4,
  output logic            if_id_valid,
  output logic            misalign_err,
  output logic [15:0]     fetch_cnt
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
  localparam logic [15:0]     CNT_MAX = 16'hFFFF;

  logic [PC_W-1:0] pc_q,        pc_d;
  logic [31:0]     ins_q,       ins_d;
  logic [PC_W-1:0] id_pc_q,     id_pc_d;
  logic [PC_W-1:0] id_pc4_q,    id_pc4_d;
  logic            valid_q,     valid_d;
  logic            mis_q,       mis_d;
  logic [15:0]     cnt_q,       cnt_d;

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redirect_aligned;

  // Sequential address arithmetic; wraps naturally at 2^PC_W.
  assign pc_plus4         = pc_q + PC_STEP;
  // Low two bits are forced to zero so a bad target can never cause an
  // unaligned fetch; the misalignment is reported instead.
  assign redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};

  // Next-state selection with priority redirect > stall > advance.
  always_comb begin
    pc_d     = pc_q;
    ins_d    = ins_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    valid_d  = valid_q;
    mis_d    = 1'b0;
    cnt_d    = cnt_q;
    if (redirect) begin
      // Flush drops the stalled or in-flight instruction; the IF/ID
      // address fields keep their last values.
      pc_d    = redirect_aligned;
      ins_d   = NOP_INS;
      valid_d = 1'b0;
      mis_d   = (redirect_pc[1:0] != 2'b00);
    end else if (!stall) begin
      pc_d     = pc_plus4;
      ins_d    = Ins;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      valid_d  = 1'b1;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // State registers with synchronous reset overriding all other requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= {RESET_PC[PC_W-1:2], 2'b00};
      ins_q    <= NOP_INS;
      id_pc_q  <= '0;
      id_pc4_q <= PC_STEP;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      ins_q    <= ins_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign if_id_ins    = ins_q;
  assign if_id_pc     = id_pc_q;
  assign if_id_pc4    = id_pc4_q;
  assign if_id_valid  = valid_q;
  assign misalign_err = mis_q;
  assign fetch_cnt    = cnt_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the pipelined CPU. Owns the program counter and drives the byte address into the combinational instruction memory. Latches the returned 32-bit instruction into the IF/ID pipeline register. Handles stall (hold), redirect (branch/jump target load plus IF/ID flush) and a saturating fetch counter for performance debug.

Parameters:
PC_W, 10, width of the byte-addressed PC; matches the instruction memory address width.
RESET_PC, 0, PC value loaded on reset; must be word aligned.
NOP_INS, 32'h0000_0000, instruction word injected into IF/ID on reset and flush.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
pc  output  PC_W  current fetch address to the instruction memory; always word aligned
Ins  input  32  instruction returned combinationally by the instruction memory for pc
stall  input  1  hazard unit request: hold PC and IF/ID
redirect  input  1  branch/jump taken: load redirect_pc and flush IF/ID
redirect_pc  input  PC_W  redirect target byte address
if_id_ins  output  32  latched instruction for decode
if_id_pc  output  PC_W  address of if_id_ins
if_id_pc4  output  PC_W  if_id_pc + 4, modulo 2^PC_W
if_id_valid  output  1  if_id_ins is a real fetched instruction (0 = bubble)
misalign_err  output  1  one-cycle pulse: a redirect target had nonzero bits [1:0]
fetch_cnt  output  16  count of instructions accepted into IF/ID

Behaviour:
- Memory is combinational. Ins is sampled in the same cycle pc is driven; no fetch wait state.
- Per rising edge, priority: rst > redirect > stall > advance.
- rst:
  - pc <= RESET_PC.
  - if_id_ins <= NOP_INS; if_id_pc <= 0; if_id_pc4 <= 4; if_id_valid <= 0.
  - misalign_err <= 0; fetch_cnt <= 0.
  - Applies mid-operation too, overriding any concurrent redirect or stall.
- redirect (rst=0):
  - pc <= {redirect_pc[PC_W-1:2], 2'b00}.
  - IF/ID flushed: if_id_ins <= NOP_INS, if_id_valid <= 0. if_id_pc and if_id_pc4 hold.
  - misalign_err <= (redirect_pc[1:0] != 0).
  - fetch_cnt unchanged.
  - Redirect overrides a simultaneous stall, so the stalled instruction is discarded.
- stall (rst=0, redirect=0):
  - pc and all IF/ID outputs hold; fetch_cnt holds.
  - misalign_err <= 0.
  - Stall may be held for any number of cycles.
- advance (no rst/redirect/stall):
  - if_id_ins <= Ins; if_id_pc <= pc; if_id_pc4 <= pc + 4.
  - if_id_valid <= 1.
  - pc <= pc + 4, truncated to PC_W bits.
  - fetch_cnt <= fetch_cnt + 1, saturating at 16'hFFFF.
  - misalign_err <= 0.
- Wrap-around: for PC_W=10, pc 1020 advances to 0; if_id_pc4 for if_id_pc=1020 is 0.
- Latency: the instruction at address A appears on if_id_ins one edge after pc==A on an advance cycle.
- The first edge after reset release latches the RESET_PC instruction. if_id_valid is 0 for exactly the one cycle before that edge.
- pc[1:0] is always 00; no path can produce an unaligned fetch.

Test Plan:
1. Reset then 4 free-run cycles with memory word k = 32'h1000_0000+k → if_id_pc 0, 4, 8, 12; if_id_ins 10000000..10000003; if_id_valid 1 from first edge after reset; fetch_cnt 4.
2. Stall high for 3 cycles at pc=8 → pc stays 8; if_id_pc stays 4 with its instruction; fetch_cnt frozen. After release, the next edge latches pc=8's word.
3. redirect with redirect_pc=0x40 while stall=1 → next cycle pc=0x40, if_id_ins=NOP_INS, if_id_valid=0, misalign_err=0. The following edge latches the word at 0x40 with valid=1.
4. redirect_pc=0x46 → pc=0x44, misalign_err high for exactly one cycle, IF/ID flushed.
5. redirect to 1020, then 2 advances → if_id_pc 1020 with if_id_pc4 0, then if_id_pc 0; pc 4.
6. rst asserted mid-run together with redirect and stall → next cycle pc=RESET_PC, if_id_valid=0, fetch_cnt=0, misalign_err=0. Also force fetch_cnt to FFFF and advance → it stays FFFF.
